// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller and its neighbours.
package ram_fifo_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  // Direction of the most recent granted RAM access, used to break push/pop ties.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push port, pop port and single-port RAM bus of the FIFO controller.
interface ram_fifo_ctrl_if;
  import ram_fifo_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  logic              ram_ena;
  logic              ram_wena;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // master: the controller; slave: the producer/consumer/RAM environment.
  modport master (
    input  in_valid, in_data, out_ready, ram_rdata,
    output in_ready, out_valid, out_data, ram_ena, ram_wena, ram_addr, ram_wdata
  );

  modport slave (
    output in_valid, in_data, out_ready, ram_rdata,
    input  in_ready, out_valid, out_data, ram_ena, ram_wena, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_fifo_ctrl.sv
// Presents a single-port 32x32 RAM as a synchronous FIFO with a one-word prefetch
// output register; pushes and RAM reads share the port and alternate on contention.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  ram_fifo_ctrl_if.master     bus,
  output logic [ADDR_W:0]     level
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   level_reg;
  logic [ADDR_W:0]   level_next;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  op_e               last_op_reg;

  logic slot_free;
  logic rd_req;
  logic in_ready;
  logic wr_grant;
  logic rd_grant;

  // in_ready deliberately ignores in_valid so the producer sees a stable ready.
  always_comb begin
    slot_free = !out_valid_reg || bus.out_ready;
    rd_req    = slot_free && (level_reg != '0);
    in_ready  = rst_n && !flush && (level_reg != FULL_LEVEL)
                && !(rd_req && (last_op_reg == OP_WR));
    wr_grant  = bus.in_valid && in_ready;
    rd_grant  = rd_req && !wr_grant && !flush;
  end

  always_comb begin
    level_next = level_reg;
    if (wr_grant && !rd_grant) begin
      level_next = level_reg + 1'b1;
    end else if (rd_grant && !wr_grant) begin
      level_next = level_reg - 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.ram_ena   = wr_grant || rd_grant;
  assign bus.ram_wena  = wr_grant;
  assign bus.ram_addr  = wr_grant ? wr_ptr_reg : rd_ptr_reg;
  assign bus.ram_wdata = bus.in_data;
  assign level         = level_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      last_op_reg   <= OP_RD;
    end else if (flush) begin
      // out_data keeps its stale value; out_valid guards it.
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      out_valid_reg <= 1'b0;
      last_op_reg   <= OP_RD;
    end else begin
      level_reg <= level_next;
      if (wr_grant) begin
        wr_ptr_reg  <= wr_ptr_reg + 1'b1;
        last_op_reg <= OP_WR;
      end
      if (rd_grant) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        out_data_reg  <= bus.ram_rdata;
        out_valid_reg <= 1'b1;
        last_op_reg   <= OP_RD;
      end else if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  a_single_access: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_grant && rd_grant));
  a_level_range: assert property (@(posedge clk) disable iff (!rst_n)
    level_reg <= FULL_LEVEL);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_grant && level_reg == FULL_LEVEL) && !(rd_grant && level_reg == '0));

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 32x32 single-port RAM attached.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [ADDR_W:0] level;

  ram_fifo_ctrl_if bus();

  ram_fifo_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.master),
    .level (level)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_ena && bus.ram_wena) mem[bus.ram_addr] <= bus.ram_wdata;
  end
  assign bus.ram_rdata = mem[bus.ram_addr];

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] sb [$];
  int          wr_cnt  = 0;
  int          rd_cnt  = 0;
  logic        snap_ena, snap_wena, snap_ready, snap_acc, snap_pop;

  // One clock: drive at negedge, observe handshakes before the edge, check after it.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
    logic [31:0] exp;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    snap_ena   = bus.ram_ena;
    snap_wena  = bus.ram_wena;
    snap_ready = bus.in_ready;
    snap_acc   = iv && bus.in_ready;
    snap_pop   = bus.out_valid && ordy && !fl;
    if (snap_pop) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %08h, required no word", bus.out_data);
      end else begin
        exp = sb.pop_front();
        if (bus.out_data !== exp) begin
          errors++;
          $display("FAIL pop_data: got %08h, required %08h", bus.out_data, exp);
        end else begin
          $display("pop  %08h", exp);
        end
      end
    end
    if (snap_acc) begin
      sb.push_back(id);
      $display("push %08h", id);
    end
    if (fl) begin
      vectors++;
      if (snap_ena !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_access: ram_ena %b, required 0", snap_ena);
      end
    end
    if (snap_ena === 1'b1) begin
      vectors++;
      if (snap_wena) begin
        if (bus.ram_addr !== ADDR_W'(wr_cnt)) begin
          errors++;
          $display("FAIL wr_addr: got %0d, required %0d", bus.ram_addr, wr_cnt % DEPTH);
        end
        wr_cnt++;
      end else begin
        if (bus.ram_addr !== ADDR_W'(rd_cnt)) begin
          errors++;
          $display("FAIL rd_addr: got %0d, required %0d", bus.ram_addr, rd_cnt % DEPTH);
        end
        rd_cnt++;
      end
    end else if (bus.ram_wena !== 1'b0) begin
      vectors++;
      errors++;
      $display("FAIL idle_wena: ram_wena %b with ram_ena 0, required 0", bus.ram_wena);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      wr_cnt = 0;
      rd_cnt = 0;
    end
    vectors++;
    if (int'(level) + int'(bus.out_valid) != sb.size()) begin
      errors++;
      $display("FAIL occupancy: level %0d + out_valid %b, required %0d words", level, bus.out_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) cycle(1'b1, 32'h5E5E_0000, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
    if (bus.in_ready  !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); end
    if (bus.ram_ena   !== 1'b0) begin errors++; $display("FAIL rst_ram_ena: got %b, required 0", bus.ram_ena); end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    #1;
    vectors++;
    if (level !== '0) begin errors++; $display("FAIL rst_level: got %0d, required 0", level); end
  endtask

  task automatic test_latency();
    cycle(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    vectors += 3;
    if (!(snap_ena === 1'b1 && snap_wena === 1'b1)) begin
      errors++; $display("FAIL lat_write: ena %b wena %b, required 1 1", snap_ena, snap_wena);
    end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b, required 0", bus.out_valid); end
    if (level !== 6'd1) begin errors++; $display("FAIL lat_level: got %0d, required 1", level); end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    vectors += 3;
    if (!(snap_ena === 1'b1 && snap_wena === 1'b0)) begin
      errors++; $display("FAIL lat_read: ena %b wena %b, required 1 0", snap_ena, snap_wena);
    end
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b, required 1", bus.out_valid); end
    if (bus.out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL lat_data: got %08h, required a5a50001", bus.out_data); end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_fill();
    int nxt = 0;
    int pops = 0;
    for (int k = 0; k < 80; k++) begin
      cycle(1'b1, 32'(nxt), 1'b0, 1'b0);
      if (snap_acc) nxt++;
    end
    vectors += 4;
    if (nxt != 33) begin errors++; $display("FAIL fill_accepted: got %0d, required 33", nxt); end
    if (level !== 6'd32) begin errors++; $display("FAIL fill_level: got %0d, required 32", level); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b, required 0", bus.in_ready); end
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid: got %b, required 1", bus.out_valid); end
    for (int k = 0; k < 200 && sb.size() > 0; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      if (snap_pop) pops++;
    end
    vectors++;
    if (pops != 33) begin errors++; $display("FAIL fill_drained: got %0d words, required 33", pops); end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int budget = 3000;
    logic iv;
    while ((pushed < 100 || sb.size() > 0) && budget > 0) begin
      iv = (pushed < 100) && ($urandom_range(0, 9) < 7);
      cycle(iv, 32'hC000_0000 + 32'(pushed), 1'($urandom_range(0, 1)), 1'b0);
      if (snap_acc) pushed++;
      budget--;
    end
    vectors += 2;
    if (budget == 0) begin errors++; $display("FAIL wrap_timeout: pushed %0d, pending %0d, required 100, 0", pushed, sb.size()); end
    if (level !== '0) begin errors++; $display("FAIL wrap_level: got %0d, required 0", level); end
  endtask

  task automatic test_tie();
    logic [31:0] nxt = 32'h7000_0000;
    logic        prev_wena = 1'b0;
    cycle(1'b1, nxt, 1'b0, 1'b0); if (snap_acc) nxt++;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, nxt, 1'b0, 1'b0); if (snap_acc) nxt++;
    cycle(1'b1, nxt, 1'b0, 1'b0); if (snap_acc) nxt++;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, nxt, 1'b1, 1'b0);
      if (snap_acc) nxt++;
      vectors++;
      if (snap_ena !== 1'b1 || (k == 0 && snap_wena !== 1'b0) || (k > 0 && snap_wena === prev_wena)) begin
        errors++;
        $display("FAIL tie_alternate: cycle %0d ena %b wena %b prev %b, required ena 1 and wena flipping", k, snap_ena, snap_wena, prev_wena);
      end
      prev_wena = snap_wena;
    end
    for (int k = 0; k < 40 && sb.size() > 0; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    int nxt = 0;
    for (int k = 0; k < 60 && level != 6'd10; k++) begin
      cycle(1'b1, 32'h1000_0000 + 32'(nxt), 1'b0, 1'b0);
      if (snap_acc) nxt++;
    end
    vectors++;
    if (level !== 6'd10 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_setup: level %0d out_valid %b, required 10 1", level, bus.out_valid);
    end
    cycle(1'b1, 32'hDEAD_DEAD, 1'b1, 1'b1);
    vectors += 3;
    if (snap_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b, required 0", snap_ready); end
    if (level !== '0) begin errors++; $display("FAIL flush_level: got %0d, required 0", level); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, required 0", bus.out_valid); end
    cycle(1'b1, 32'hBEEF_0001, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hBEEF_0001) begin
      errors++; $display("FAIL flush_next_word: valid %b data %08h, required 1 beef0001", bus.out_valid, bus.out_data);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_latency();
    test_fill();
    test_wrap();
    test_tie();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
